rs_ff_credit_ctrl: RTL

- Flow-control controller for a latency-insensitive link built from a chain of unreset feed-forward register stages.
- Register stages run both ways: data+valid forward, credit pulses backward.
- Upstream side: issues data while credits remain. Downstream side: buffers arrivals in a receive FIFO and returns one credit per pop.
- The external stages never stall. Backpressure is handled only here, so the stages can be floorplan-inserted freely across slot boundaries.

---
 rtl/rs_ff_pkg.sv | 27 ++
 rtl/rs_ff_credit_fifo.sv | 69 ++++++
 rtl/rs_ff_credit_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rs_ff_pkg.sv
// Shared types and helpers for the credit-based feed-forward link controller.
package rs_ff_pkg;

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Ceiling log2 for parameter arithmetic; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned pow;
    res = 0;
    pow = 1;
    while (pow < value) begin
      pow = pow << 1;
      res = res + 1;
    end
    return res;
  endfunction

  // Legal configuration: depth a power of two >= 2, at most 15 stages per direction.
  function automatic bit params_ok(input int unsigned depth, input int unsigned latency);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) && (latency <= 15);
  endfunction

endpackage

// File: rtl/rs_ff_credit_fifo.sv
// Show-ahead receive FIFO with a sticky overflow flag; a push while full is dropped.
module rs_ff_credit_fifo
  import rs_ff_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  overflow
);

  localparam int unsigned AW   = clog2(DEPTH);
  localparam int unsigned CNTW = clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [CNTW-1:0]       count;
  logic                  full;
  logic                  rd_en_c;
  logic                  wr_en_c;

  assign empty   = (count == '0);
  assign full    = (count == CNTW'(DEPTH));
  assign rd_en_c = pop && !empty;
  // A pop frees the slot in the same cycle, so push+pop at full is legal.
  assign wr_en_c = push && (!full || rd_en_c);
  // Gate with empty so stale, unreset storage never reaches the port.
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array, deliberately without reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en_c && !rd_en_c) begin
        count <= count + CNTW'(1);
      end else if (rd_en_c && !wr_en_c) begin
        count <= count - CNTW'(1);
      end
      if (push && full && !rd_en_c) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_ff_credit_ctrl.sv
// Credit-based flow control across a chain of unreset feed-forward register stages.
module rs_ff_credit_ctrl
  import rs_ff_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned PIPE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_din_valid,
  output logic                  if_din_ready,
  output logic [DATA_WIDTH-1:0] pipe_in_data,
  output logic                  pipe_in_valid,
  input  logic [DATA_WIDTH-1:0] pipe_out_data,
  input  logic                  pipe_out_valid,
  output logic                  credit_out,
  input  logic                  credit_in,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_dout_valid,
  input  logic                  if_dout_ready,
  output logic                  err_overflow,
  output logic                  err_credit
);

  localparam int unsigned CW  = clog2(FIFO_DEPTH + 1);
  localparam int unsigned FCW = 4;

  if (!params_ok(FIFO_DEPTH, PIPE_LATENCY)) begin : g_bad_params
    $error("rs_ff_credit_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and PIPE_LATENCY <= 15");
  end

  state_e         state_q;
  state_e         state_d;
  logic [FCW-1:0] flush_cnt;
  logic [CW-1:0]  credit;
  logic           run_c;
  logic           accept_c;
  logic           push_c;
  logic           pop_c;
  logic           fifo_empty;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FLUSH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave FLUSH once the unreset stages have drained their garbage.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FLUSH:   if (flush_cnt == FCW'(PIPE_LATENCY)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = FLUSH;
    endcase
  end

  // State decode: everything on the link is ignored or held off outside RUN.
  always_comb begin
    run_c = 1'b0;
    case (state_q)
      RUN:     run_c = 1'b1;
      default: run_c = 1'b0;
    endcase
  end

  // Flush cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (state_q == FLUSH) begin
      flush_cnt <= flush_cnt + FCW'(1);
    end
  end

  assign if_din_ready = run_c && (credit != '0);
  assign accept_c     = if_din_valid && if_din_ready;
  assign push_c       = run_c && pipe_out_valid;
  assign if_dout_valid = !fifo_empty;
  assign pop_c        = if_dout_valid && if_dout_ready;

  // Send register into the forward chain; data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_in_valid <= 1'b0;
      pipe_in_data  <= '0;
    end else begin
      pipe_in_valid <= accept_c;
      if (accept_c) begin
        pipe_in_data <= if_din;
      end
    end
  end

  // Credit counter: spend on accept, refund on credit_in, saturate at the FIFO depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit     <= CW'(FIFO_DEPTH);
      err_credit <= 1'b0;
    end else if (run_c) begin
      if (credit_in && !accept_c) begin
        if (credit == CW'(FIFO_DEPTH)) begin
          err_credit <= 1'b1;
        end else begin
          credit <= credit + CW'(1);
        end
      end else if (accept_c && !credit_in) begin
        credit <= credit - CW'(1);
      end
    end
  end

  // One credit pulse into the return chain per pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_out <= 1'b0;
    end else begin
      credit_out <= pop_c;
    end
  end

  rs_ff_credit_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (pipe_out_data),
    .pop       (pop_c),
    .dout      (if_dout),
    .empty     (fifo_empty),
    .overflow  (err_overflow)
  );

endmodule
